timer_dev: RTL

Memory-mapped 32-bit countdown timer on the core's data-memory port, in parallel with DM. The M-stage address, store data and write enable are decoded at `BASE_ADDR`; matching stores program the timer and loads return its registers. An expiry raises a sticky interrupt request toward the core, as the first device behind the future system bridge.

---
 rtl/timer_dev_if.sv | 13 +
 rtl/timer_dev.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/timer_dev_if.sv
// Data-memory side bus of the countdown timer: M-stage address/store data in,
// combinational read data, window hit and interrupt request out.
interface timer_dev_if;
  logic [31:0] Addr_In;
  logic [31:0] D_In;
  logic        MemWrite_In;
  logic [31:0] D_Out;
  logic        Hit_Out;
  logic        Irq_Out;

  modport master (output Addr_In, D_In, MemWrite_In, input D_Out, Hit_Out, Irq_Out);
  modport slave  (input Addr_In, D_In, MemWrite_In, output D_Out, Hit_Out, Irq_Out);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped 32-bit countdown timer sitting beside data memory.
// Window at BASE_ADDR: 0x0 CTRL {IM,MODE[1:0],EN}, 0x4 PRESET, 0x8 COUNT (RO),
// 0xC PRESCALE. Optional prescaler enabled with macro TIMER_PRESCALE_EN.
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input logic       Clk,
  input logic       Reset,
  timer_dev_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q;
  logic        tick;
  logic [1:0]  off;
  logic        wr_ctrl, wr_preset, wr_pscl;
  logic [31:0] rdata;
  logic        unused_ok;

  assign bus.Hit_Out = (bus.Addr_In[31:4] == BASE_ADDR[31:4]);
  assign off         = bus.Addr_In[3:2];
  assign wr_ctrl     = bus.MemWrite_In & bus.Hit_Out & (off == 2'd0);
  assign wr_preset   = bus.MemWrite_In & bus.Hit_Out & (off == 2'd1);
  assign wr_pscl     = bus.MemWrite_In & bus.Hit_Out & (off == 2'd3);
  assign unused_ok   = ^bus.Addr_In[1:0];
  assign bus.Irq_Out = irq_q;
  assign bus.D_Out   = rdata;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] pscl_q, pscl_d, div_q, div_d;

  // One tick every PRESCALE+1 cycles while counting.
  assign tick = (div_q == pscl_q);

  // Divider restarts on every reload and whenever the ratio changes.
  always_comb begin
    pscl_d = pscl_q;
    div_d  = div_q;
    if (wr_pscl) pscl_d = bus.D_In[7:0];
    if (wr_pscl || state_q == LOAD) div_d = 8'd0;
    else if (state_q == CNT && ctrl_q.en) div_d = tick ? 8'd0 : div_q + 8'd1;
  end

  // Prescaler and divider registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pscl_q <= 8'd0;
      div_q  <= 8'd0;
    end else begin
      pscl_q <= pscl_d;
      div_q  <= div_d;
    end
  end
`else
  assign tick = 1'b1;
  logic unused_pscl;
  assign unused_pscl = wr_pscl;
`endif

  // Read mux; no side effects, zero outside the window.
  always_comb begin
    rdata = 32'd0;
    if (bus.Hit_Out) begin
      case (off)
        2'd0: rdata = {28'd0, ctrl_q};
        2'd1: rdata = preset_q;
        2'd2: rdata = count_q;
`ifdef TIMER_PRESCALE_EN
        2'd3: rdata = {24'd0, pscl_q};
`endif
        default: rdata = 32'd0;
      endcase
    end
  end

  // Next state: FSM first, then bus writes override CTRL, but an expiry on the
  // same edge still sets the flag so the event is never lost.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    case (state_q)
      IDLE: if (ctrl_q.en) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q.en)             state_d = IDLE;
        else if (count_q == 32'd0) state_d = INT;
        else if (tick)             count_d = count_q - 32'd1;
      end
      INT: begin
        if (!ctrl_q.en)                 state_d = IDLE;
        else if (ctrl_q.mode == 2'b01) state_d = LOAD;
        else begin
          ctrl_d.en = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_preset) preset_d = bus.D_In;
    if (wr_ctrl) begin
      ctrl_d     = ctrl_t'(bus.D_In[3:0]);
      irq_flag_d = 1'b0;
    end
    if (state_q == CNT && ctrl_q.en && count_q == 32'd0) irq_flag_d = 1'b1;
  end

  // State registers; IRQ output is registered from the next flag and mask.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_flag_d & ctrl_d.im;
    end
  end

endmodule
